pwm_fade_ctrl: RTL and testbench

Sequencer that owns the threshold-write port of the `pwm` block. It holds a target duty and a ramp step per channel and moves each channel's live threshold toward its target, one channel per PWM period, round-robin. Every write is presented so that it is captured on the counter `overflow` cycle, which is the only cycle in which `pwm` accepts a new threshold. It sits between the register/host interface and `pwm`, and shares the `overflow` pulse from the same `counter` instance.

---
 rtl/pwm_fade_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Threshold-write sequencer for the pwm block: ramps each channel's live threshold
// toward its target, one committed write per counter overflow, round-robin.
module pwm_fade_ctrl #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       overflow,
    input  logic                       cfg_we,
    input  logic [$clog2(num_pwm)-1:0] cfg_chan,
    input  logic [pwm_width-1:0]       cfg_target,
    input  logic [pwm_width-1:0]       cfg_step,
    output logic [pwm_width-1:0]       new_thres,
    output logic [$clog2(num_pwm)-1:0] sel_thres,
    output logic                       set_thres,
    output logic                       busy
);

    localparam int CW = $clog2(num_pwm);
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [CW:0]   NCH     = (CW+1)'(num_pwm);
    localparam logic [CW-1:0] LAST_CH = CW'(num_pwm - 1);

    // Step rule evaluated one bit wider so the distance and sums cannot wrap.
    function automatic logic [pwm_width-1:0] step_next(
        input logic [pwm_width-1:0] cur,
        input logic [pwm_width-1:0] tgt,
        input logic [pwm_width-1:0] stp
    );
        logic [pwm_width:0] diff;
        logic [pwm_width:0] res;
        if (cur < tgt) diff = {1'b0, tgt} - {1'b0, cur};
        else           diff = {1'b0, cur} - {1'b0, tgt};
        if (stp == '0 || diff <= {1'b0, stp}) res = {1'b0, tgt};
        else if (cur < tgt)                   res = {1'b0, cur} + {1'b0, stp};
        else                                  res = {1'b0, cur} - {1'b0, stp};
        return res[pwm_width-1:0];
    endfunction

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        k_q, k_d;
    logic [CW-1:0]        last_q, last_d;
    logic [pwm_width-1:0] new_q, new_d;
    logic [CW-1:0]        sel_q, sel_d;
    logic                 set_q, set_d;
    logic                 busy_q, busy_d;
    logic                 commit;

    logic [pwm_width-1:0] cur_q    [num_pwm];
    logic [pwm_width-1:0] target_q [num_pwm];
    logic [pwm_width-1:0] step_q   [num_pwm];

    logic [CW:0]          cand;
    logic                 found;
    logic [CW-1:0]        ch;
    logic [pwm_width-1:0] nxt;
    logic                 cfg_ok;

    assign cfg_ok = cfg_we && ({1'b0, cfg_chan} < NCH);

    // Round-robin search from last+1; inequality is a plain XOR-reduce.
    always_comb begin
        found = 1'b0;
        ch    = '0;
        cand  = '0;
        for (int i = 1; i <= num_pwm; i++) begin
            cand = {1'b0, last_q} + (CW+1)'(i);
            if (cand >= NCH) cand = cand - NCH;
            if (!found && (|(cur_q[cand[CW-1:0]] ^ target_q[cand[CW-1:0]]))) begin
                found = 1'b1;
                ch    = cand[CW-1:0];
            end
        end
    end

    assign nxt = step_next(cur_q[ch], target_q[ch], step_q[ch]);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        new_d   = new_q;
        sel_d   = sel_q;
        set_d   = set_q;
        busy_d  = 1'b1;
        commit  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (overflow) begin
                    if (k_q == LAST_CH) begin
                        state_d = ST_SCAN;
                        set_d   = 1'b0;
                    end else begin
                        k_d   = k_q + CW'(1);
                        sel_d = k_q + CW'(1);
                    end
                end
            end
            ST_SCAN: begin
                busy_d = found;
                if (found) begin
                    new_d   = nxt;
                    sel_d   = ch;
                    set_d   = 1'b1;
                    last_d  = ch;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (overflow) begin
                    commit  = 1'b1;
                    set_d   = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_INIT;
                k_d     = '0;
                new_d   = '0;
                sel_d   = '0;
                set_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            k_q     <= '0;
            last_q  <= LAST_CH;
            new_q   <= '0;
            sel_q   <= '0;
            set_q   <= 1'b1;
            busy_q  <= 1'b1;
            for (int i = 0; i < num_pwm; i++) begin
                cur_q[i]    <= '0;
                target_q[i] <= '0;
                step_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            new_q   <= new_d;
            sel_q   <= sel_d;
            set_q   <= set_d;
            busy_q  <= busy_d;
            if (commit) cur_q[sel_q] <= new_q;
            if (cfg_ok) begin
                target_q[cfg_chan] <= cfg_target;
                step_q[cfg_chan]   <= cfg_step;
            end
        end
    end

    assign new_thres = new_q;
    assign sel_thres = sel_q;
    assign set_thres = set_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios with literal commit
// sequences plus randomized traffic against a transaction-level reference model.
module tb_pwm_fade_ctrl;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         overflow = 1'b0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_chan = '0;
    logic [W-1:0] cfg_target = '0;
    logic [W-1:0] cfg_step = '0;
    logic [W-1:0] new_thres;
    logic [1:0]   sel_thres;
    logic         set_thres;
    logic         busy;

    pwm_fade_ctrl #(.pwm_width(W), .num_pwm(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .overflow   (overflow),
        .cfg_we     (cfg_we),
        .cfg_chan   (cfg_chan),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .new_thres  (new_thres),
        .sel_thres  (sel_thres),
        .set_thres  (set_thres),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ovf_cnt  = 0;
    bit rand_ovf = 1'b0;

    int dlog[$];
    int mlog[$];
    int want[$];

    // Reference model: committed values, targets, steps, one optional pending write.
    bit m_init, m_pend;
    int m_k, m_pch, m_pval, m_last;
    int m_cur[N], m_tgt[N], m_stp[N];
    int e_new, e_sel, e_set, e_busy;
    int fc, cc;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int c, input int t, input int s);
        int d;
        d = (t > c) ? t - c : c - t;
        if (s == 0 || d <= s) return t;
        return (c < t) ? c + s : c - s;
    endfunction

    task model_reset();
        m_init = 1'b1; m_pend = 1'b0; m_k = 0; m_last = N - 1;
        m_pch = 0; m_pval = 0;
        for (int i = 0; i < N; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_stp[i] = 0;
        end
        e_new = 0; e_sel = 0; e_set = 1; e_busy = 1;
    endtask

    task model_advance();
        if (m_init) begin
            e_busy = 1;
            if (overflow) begin
                mlog.push_back(m_k * 256);
                if (m_k == N - 1) begin
                    m_init = 1'b0;
                    e_set  = 0;
                end else begin
                    m_k   = m_k + 1;
                    e_sel = m_k;
                end
            end
        end else if (m_pend) begin
            e_busy = 1;
            if (overflow) begin
                m_cur[m_pch] = m_pval;
                mlog.push_back(m_pch * 256 + m_pval);
                m_pend = 1'b0;
                e_set  = 0;
            end
        end else begin
            fc = -1;
            for (int j = 1; j <= N; j++) begin
                cc = (m_last + j) % N;
                if (fc < 0 && m_cur[cc] != m_tgt[cc]) fc = cc;
            end
            if (fc >= 0) begin
                m_pval = model_next(m_cur[fc], m_tgt[fc], m_stp[fc]);
                m_pch  = fc;
                m_last = fc;
                m_pend = 1'b1;
                e_new  = m_pval;
                e_sel  = fc;
                e_set  = 1;
                e_busy = 1;
            end else begin
                e_busy = 0;
            end
        end
        if (cfg_we) begin
            m_tgt[cfg_chan] = int'(cfg_target);
            m_stp[cfg_chan] = int'(cfg_step);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("new_thres", int'(new_thres), e_new);
            chk("sel_thres", int'(sel_thres), e_sel);
            chk("set_thres", int'(set_thres), e_set);
            chk("busy", int'(busy), e_busy);
            if (rst_n) begin
                if (set_thres && overflow) dlog.push_back(int'(sel_thres) * 256 + int'(new_thres));
                model_advance();
            end
        end
    end

    task tick();
        @(posedge clk);
        #2;
        ovf_cnt++;
        if (rand_ovf) overflow = ($urandom_range(0, 3) == 0);
        else          overflow = ((ovf_cnt % 16) == 15);
    endtask

    task cfg_write(input int ch, input int tgt, input int stp);
        cfg_we     = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_target = W'(tgt);
        cfg_step   = W'(stp);
        tick();
        cfg_we = 1'b0;
    endtask

    task wait_idle(input string name);
        int n;
        repeat (3) tick();
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, (n < 4000) ? 1 : 0, 1);
    endtask

    task check_log(input string name);
        chk({name, "_len"}, dlog.size(), want.size());
        chk({name, "_model_len"}, mlog.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            chk(name, (i < dlog.size()) ? dlog[i] : -1, want[i]);
            chk({name, "_model"}, (i < mlog.size()) ? mlog[i] : -1, want[i]);
        end
        dlog.delete();
        mlog.delete();
        want.delete();
    endtask

    initial begin
        int n;

        // Reset and INIT sweep
        repeat (3) tick();
        rst_n = 1'b1;
        wait_idle("t1");
        want = '{'h000, 'h100, 'h200, 'h300};
        check_log("t1_init");
        chk("t1_set_idle", int'(set_thres), 0);
        chk("t1_busy_idle", int'(busy), 0);

        // Single ramp on ch1
        cfg_write(1, 'h40, 'h10);
        wait_idle("t2");
        want = '{'h110, 'h120, 'h130, 'h140};
        check_log("t2_ramp");

        // Clamp at target, then ramp down
        cfg_write(2, 'h25, 'h10);
        wait_idle("t3a");
        cfg_write(2, 'h03, 'h10);
        wait_idle("t3b");
        want = '{'h210, 'h220, 'h225, 'h215, 'h205, 'h203};
        check_log("t3_clamp");

        // Round-robin between two ramping channels
        cfg_write(0, 'hFF, 'h80);
        cfg_write(3, 'hFF, 'h80);
        wait_idle("t4");
        want = '{'h080, 'h380, 'h0FF, 'h3FF};
        check_log("t4_rr");

        // Step 0 jumps directly, full-scale both ways
        cfg_write(1, 'hFF, 0);
        wait_idle("t5a");
        cfg_write(1, 'h00, 0);
        wait_idle("t5b");
        want = '{'h1FF, 'h100};
        check_log("t5_jump");

        // Config write to the pending channel in its commit cycle
        cfg_write(2, 'h43, 'h20);
        n = 0;
        while (!(set_thres === 1'b1 && overflow === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("t6a_commit_timeout", (n < 200) ? 1 : 0, 1);
        cfg_write(2, 'h10, 0);
        wait_idle("t6a");
        want = '{'h223, 'h210};
        check_log("t6a_same_cycle");

        // Reset while a write is pending
        cfg_write(1, 'h80, 'h10);
        n = 0;
        while (!(set_thres === 1'b1 && overflow === 1'b0) && n < 200) begin
            tick();
            n++;
        end
        chk("t6b_pend_timeout", (n < 200) ? 1 : 0, 1);
        chk("t6b_pre_sel", int'(sel_thres), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6b_rst_new", int'(new_thres), 0);
        chk("t6b_rst_sel", int'(sel_thres), 0);
        chk("t6b_rst_set", int'(set_thres), 1);
        chk("t6b_rst_busy", int'(busy), 1);
        dlog.delete();
        mlog.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        wait_idle("t6b");
        want = '{'h000, 'h100, 'h200, 'h300};
        check_log("t6b_reinit");

        // Randomized traffic with irregular overflow spacing
        rand_ovf = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)), 0);
                    1:       cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)), int'($urandom_range(16, 255)));
                    default: cfg_write(int'($urandom_range(0, N - 1)), (($urandom_range(0, 1) == 0) ? 0 : 255), int'($urandom_range(16, 127)));
                endcase
            end else begin
                tick();
            end
        end
        wait_idle("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
